tree_encoder_pipe: RTL and testbench
====================================

TREE_ENCODER_PIPE -- requirements
Module: tree_encoder_pipe

Interface
REQ-001 Parameter NWIN, default 16: window count; power of 2, range 2..64.
REQ-002 Parameter PRI_BITS, default 4: priority width per window, range 1..8.
REQ-003 Derived constant LOGW = clog2(NWIN); pipeline latency L = LOGW clocks.
REQ-004 clock  in  1  single clock; all state on rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 win_pri  in  NWIN*PRI_BITS  flat priority bus; window i occupies bits [i*PRI_BITS +: PRI_BITS].
REQ-007 valid_in  in  1  win_pri carries a sample this cycle.
REQ-008 flush  in  1  synchronous discard of all in-flight samples.
REQ-009 cnt_clr  in  1  synchronous clear of hit_cnt.
REQ-010 best_win  out  LOGW  index of highest-priority window.
REQ-011 best_pri  out  PRI_BITS  priority of best_win.
REQ-012 best_vld  out  1  one-cycle strobe; best_win/best_pri are new this cycle.
REQ-013 hit_cnt  out  16  count of results with best_pri != 0.

Function
REQ-014 Binary comparison tree of LOGW levels; each level registered; no backpressure, pipeline advances every cycle.
REQ-015 Each node selects the upper input only if its priority is strictly greater; ties resolve to the lower window index.
REQ-016 Each level prepends one index bit: 1 = upper input chosen, 0 = lower; final index is the full LOGW-bit window number.
REQ-017 Sample accepted on cycle N with valid_in=1 yields best_vld=1 on cycle N+L exactly; back-to-back samples give back-to-back results.
REQ-018 best_win/best_pri update only when best_vld=1; otherwise they hold the last result.
REQ-019 All-zero priorities: best_pri=0, best_win=0, best_vld still asserted.
REQ-020 valid_in=0 samples propagate as bubbles; best_vld=0 at the corresponding output cycle.
REQ-021 flush=1 clears the valid bit of every stage and the output stage; no best_vld for any sample in flight, including one presented with valid_in on the flush cycle.
REQ-022 flush does not modify best_win, best_pri or hit_cnt.
REQ-023 hit_cnt increments by 1 on each cycle with best_vld=1 and best_pri != 0; saturates at 65535, no wrap.
REQ-024 cnt_clr=1 sets hit_cnt to 0 next cycle; clear wins over a simultaneous increment.

Reset
REQ-025 reset asserted: all stage valid bits, best_vld, best_win, best_pri, hit_cnt go to 0 immediately, independent of clock.
REQ-026 Reset mid-operation discards all in-flight samples; first result after release appears L cycles after first accepted valid_in.
REQ-027 No best_vld in the first L cycles after reset release regardless of inputs.

Configuration
REQ-028 Macro TREE_ENCODER_PIPE_THRESH_EN defined: extra input pri_thresh [PRI_BITS-1:0]; windows with priority < pri_thresh are forced to 0 at tree entry, sampled on the valid_in cycle.
REQ-029 Macro TREE_ENCODER_PIPE_THRESH_EN undefined: pri_thresh port absent, no masking; behaviour identical to threshold 0.

Verification
REQ-030 NWIN=16, PRI_BITS=4: win 5 = 9, all others 3, valid_in cycle 0 -> cycle 4: best_vld=1, best_win=5, best_pri=9.
REQ-031 Windows 2, 7, 12 all = 0xF, others 0 -> best_win=2, best_pri=15 (lowest-index tie-break).
REQ-032 Four consecutive valid samples, best at windows 0, 15, 8, 3 -> best_vld high cycles 4-7, best_win 0, 15, 8, 3 in order; hit_cnt=4.
REQ-033 Valid samples cycles 0-2, flush cycle 2 -> no best_vld cycles 4-6; best_win/best_pri/hit_cnt unchanged.
REQ-034 hit_cnt preloaded to 65534 by 3 nonzero results -> holds 65535; cnt_clr with simultaneous nonzero result -> 0.
REQ-035 THRESH_EN built, pri_thresh=8, win 4 = 7, win 9 = 8, others 0 -> best_win=9, best_pri=8; all < 8 -> best_pri=0, best_win=0, hit_cnt unchanged.

Source files
------------

// File: rtl/tree_encoder_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tree_encoder_pipe
// Brief    : Pipelined binary comparison tree that finds the highest-priority
//            window of a flat priority bus. One tree level per clock, so a
//            sample appears on the outputs LOGW clocks after it is accepted.
//            Ties resolve to the lower window index. A saturating 16-bit
//            counter tracks how many results carried a nonzero priority.
// Config   : define TREE_ENCODER_PIPE_THRESH_EN to add the pri_thresh input;
//            windows below the threshold enter the tree as priority 0.
// Revision : 1.0 - initial release
// ============================================================================
module tree_encoder_pipe #(
  parameter int NWIN     = 16,
  parameter int PRI_BITS = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [NWIN*PRI_BITS-1:0]   win_pri,
  input  logic                       valid_in,
  input  logic                       flush,
  input  logic                       cnt_clr,
`ifdef TREE_ENCODER_PIPE_THRESH_EN
  input  logic [PRI_BITS-1:0]        pri_thresh,
`endif
  output logic [$clog2(NWIN)-1:0]    best_win,
  output logic [PRI_BITS-1:0]        best_pri,
  output logic                       best_vld,
  output logic [15:0]                hit_cnt
);

  localparam int LOGW  = $clog2(NWIN);
  localparam int NNODE = 2 * NWIN;

  // Tree nodes are numbered heap-style: node 1 is the root (the output
  // register), node k has children 2k (lower windows) and 2k+1 (upper
  // windows), and window i is the leaf at node NWIN+i. Indices are kept
  // full width with not-yet-decided upper bits at zero.
  logic [PRI_BITS-1:0] node_pri_d [1:NWIN-1];
  logic [PRI_BITS-1:0] node_pri_q [1:NWIN-1];
  logic [LOGW-1:0]     node_idx_d [1:NWIN-1];
  logic [LOGW-1:0]     node_idx_q [1:NWIN-1];

  // Children as seen by every node: registered internal nodes plus leaves.
  logic [PRI_BITS-1:0] all_pri [2:NNODE-1];
  logic [LOGW-1:0]     all_idx [2:NNODE-1];

  // vld bit j is the valid of tree level j+1; the top bit is best_vld.
  logic [LOGW-1:0]     vld_d;
  logic [LOGW-1:0]     vld_q;

  logic [15:0]         hit_cnt_d;
  logic [15:0]         hit_cnt_q;

  // Gather leaves (optionally thresholded) and registered nodes into one view.
  always_comb begin
    for (int k = 2; k < NNODE; k++) begin
      all_pri[k] = '0;
      all_idx[k] = '0;
    end
    for (int k = 2; k < NWIN; k++) begin
      all_pri[k] = node_pri_q[k];
      all_idx[k] = node_idx_q[k];
    end
    for (int i = 0; i < NWIN; i++) begin
      all_pri[NWIN+i] = win_pri[i*PRI_BITS +: PRI_BITS];
`ifdef TREE_ENCODER_PIPE_THRESH_EN
      if (win_pri[i*PRI_BITS +: PRI_BITS] < pri_thresh) begin
        all_pri[NWIN+i] = '0;
      end
`endif
    end
  end

  // Each node keeps the upper child only on a strict win and records the
  // decision as the index bit belonging to its tree level.
  always_comb begin
    for (int k = 1; k < NWIN; k++) begin
      if (all_pri[2*k+1] > all_pri[2*k]) begin
        node_pri_d[k] = all_pri[2*k+1];
        node_idx_d[k] = all_idx[2*k+1] | (LOGW'(1) << (LOGW - $clog2(k + 1)));
      end else begin
        node_pri_d[k] = all_pri[2*k];
        node_idx_d[k] = all_idx[2*k];
      end
    end
    // The root is the visible result, so it only moves on a valid result.
    if (!vld_d[LOGW-1]) begin
      node_pri_d[1] = node_pri_q[1];
      node_idx_d[1] = node_idx_q[1];
    end
  end

  // Valid shift chain; flush kills every in-flight sample including the input.
  always_comb begin
    vld_d[0] = valid_in & ~flush;
    for (int j = 1; j < LOGW; j++) begin
      vld_d[j] = vld_q[j-1] & ~flush;
    end
  end

  // Saturating hit counter; a clear always beats an increment.
  always_comb begin
    hit_cnt_d = hit_cnt_q;
    if (cnt_clr) begin
      hit_cnt_d = '0;
    end else if (vld_q[LOGW-1] && (node_pri_q[1] != '0) && (hit_cnt_q != 16'hFFFF)) begin
      hit_cnt_d = hit_cnt_q + 16'd1;
    end
  end

  // All pipeline, result and counter state.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      vld_q     <= '0;
      hit_cnt_q <= '0;
      for (int k = 1; k < NWIN; k++) begin
        node_pri_q[k] <= '0;
        node_idx_q[k] <= '0;
      end
    end else begin
      vld_q     <= vld_d;
      hit_cnt_q <= hit_cnt_d;
      for (int k = 1; k < NWIN; k++) begin
        node_pri_q[k] <= node_pri_d[k];
        node_idx_q[k] <= node_idx_d[k];
      end
    end
  end

  assign best_win = node_idx_q[1];
  assign best_pri = node_pri_q[1];
  assign best_vld = vld_q[LOGW-1];
  assign hit_cnt  = hit_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_tree_encoder_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_tree_encoder_pipe
// Brief    : Directed self-checking bench for tree_encoder_pipe (NWIN=16,
//            PRI_BITS=4, latency 4). Threshold steps are built only when
//            TREE_ENCODER_PIPE_THRESH_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tree_encoder_pipe;

  localparam int NWIN = 16;
  localparam int PB   = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic [63:0] win_pri;
  logic        valid_in;
  logic        flush;
  logic        cnt_clr;
`ifdef TREE_ENCODER_PIPE_THRESH_EN
  logic [3:0]  pri_thresh;
`endif
  logic [3:0]  best_win;
  logic [3:0]  best_pri;
  logic        best_vld;
  logic [15:0] hit_cnt;

  int n_checks = 0;
  int n_err    = 0;

  tree_encoder_pipe #(.NWIN(NWIN), .PRI_BITS(PB)) dut (
    .clock    (clock),
    .reset    (reset),
    .win_pri  (win_pri),
    .valid_in (valid_in),
    .flush    (flush),
    .cnt_clr  (cnt_clr),
`ifdef TREE_ENCODER_PIPE_THRESH_EN
    .pri_thresh (pri_thresh),
`endif
    .best_win (best_win),
    .best_pri (best_pri),
    .best_vld (best_vld),
    .hit_cnt  (hit_cnt)
  );

  always #5 clock = ~clock;

  function automatic logic [63:0] fill(input logic [3:0] base);
    return {16{base}};
  endfunction

  function automatic logic [63:0] put(input logic [63:0] v, input int w, input logic [3:0] p);
    logic [63:0] r;
    r = v;
    r[w*4 +: 4] = p;
    return r;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic vld, input logic [3:0] win, input logic [3:0] pri);
    chk({tag, ".vld"}, 32'(best_vld), 32'(vld));
    chk({tag, ".win"}, 32'(best_win), 32'(win));
    chk({tag, ".pri"}, 32'(best_pri), 32'(pri));
  endtask

  // Present one valid sample for one cycle; returns at cycle 1 of that sample.
  task automatic send(input logic [63:0] v);
    win_pri  = v;
    valid_in = 1'b1;
    tick();
    valid_in = 1'b0;
    win_pri  = fill(4'hF);
  endtask

  logic [63:0] v_a, v_b, v_c [4];

  initial begin
    v_a    = put(fill(4'd3), 5, 4'd9);
    v_b    = put(put(put(fill(4'd0), 2, 4'hF), 7, 4'hF), 12, 4'hF);
    v_c[0] = put(fill(4'd1), 0, 4'd6);
    v_c[1] = put(fill(4'd1), 15, 4'd7);
    v_c[2] = put(fill(4'd1), 8, 4'd8);
    v_c[3] = put(fill(4'd1), 3, 4'd9);

    reset    = 1'b1;
    win_pri  = '0;
    valid_in = 1'b0;
    flush    = 1'b0;
    cnt_clr  = 1'b0;
`ifdef TREE_ENCODER_PIPE_THRESH_EN
    pri_thresh = 4'd0;
`endif
    #1;
    chk_out("reset", 1'b0, 4'd0, 4'd0);
    chk("reset.hit", 32'(hit_cnt), 32'd0);
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;

    // Single sample right after reset release; garbage bubbles follow it.
    send(v_a);
    chk("a.c1.vld", 32'(best_vld), 32'd0);
    tick();
    chk("a.c2.vld", 32'(best_vld), 32'd0);
    tick();
    chk("a.c3.vld", 32'(best_vld), 32'd0);
    tick();
    chk_out("a.c4", 1'b1, 4'd5, 4'd9);
    tick();
    chk_out("a.c5.hold", 1'b0, 4'd5, 4'd9);
    chk("a.hit", 32'(hit_cnt), 32'd1);

    // Three-way tie at 0xF resolves to window 2.
    send(v_b);
    repeat (3) tick();
    chk_out("b.c4", 1'b1, 4'd2, 4'd15);
    tick();
    chk("b.hit", 32'(hit_cnt), 32'd2);

    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    chk("clr.hit", 32'(hit_cnt), 32'd0);

    // Four back-to-back samples.
    for (int s = 0; s < 4; s++) begin
      win_pri  = v_c[s];
      valid_in = 1'b1;
      tick();
    end
    valid_in = 1'b0;
    chk_out("c.c4", 1'b1, 4'd0, 4'd6);
    tick();
    chk_out("c.c5", 1'b1, 4'd15, 4'd7);
    tick();
    chk_out("c.c6", 1'b1, 4'd8, 4'd8);
    tick();
    chk_out("c.c7", 1'b1, 4'd3, 4'd9);
    tick();
    chk("c.c8.vld", 32'(best_vld), 32'd0);
    chk("c.hit", 32'(hit_cnt), 32'd4);

    // Samples on cycles 0-2 with flush on cycle 2: nothing emerges.
    win_pri  = v_a;
    valid_in = 1'b1;
    tick();
    tick();
    flush = 1'b1;
    tick();
    flush    = 1'b0;
    valid_in = 1'b0;
    for (int c = 3; c < 8; c++) begin
      chk($sformatf("d.c%0d.vld", c), 32'(best_vld), 32'd0);
      tick();
    end
    chk_out("d.hold", 1'b0, 4'd3, 4'd9);
    chk("d.hit", 32'(hit_cnt), 32'd4);

    // Pipeline resumes normally after a flush.
    send(v_a);
    repeat (3) tick();
    chk_out("d2.c4", 1'b1, 4'd5, 4'd9);
    tick();
    chk("d2.hit", 32'(hit_cnt), 32'd5);

    // All-zero sample: valid result, index 0, counter untouched.
    send(fill(4'd0));
    repeat (3) tick();
    chk_out("z.c4", 1'b1, 4'd0, 4'd0);
    tick();
    chk("z.hit", 32'(hit_cnt), 32'd5);

    // Counter saturation.
    cnt_clr = 1'b1;
    tick();
    cnt_clr  = 1'b0;
    win_pri  = v_a;
    valid_in = 1'b1;
    repeat (65534) tick();
    valid_in = 1'b0;
    repeat (6) tick();
    chk("sat.pre", 32'(hit_cnt), 32'd65534);
    valid_in = 1'b1;
    repeat (3) tick();
    valid_in = 1'b0;
    repeat (6) tick();
    chk("sat.hold", 32'(hit_cnt), 32'd65535);

    // Asynchronous reset with a sample in flight.
    send(v_b);
    tick();
    #2;
    reset = 1'b1;
    #1;
    chk_out("rst.async", 1'b0, 4'd0, 4'd0);
    chk("rst.async.hit", 32'(hit_cnt), 32'd0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    for (int c = 0; c < 5; c++) begin
      chk($sformatf("rst.drain%0d.vld", c), 32'(best_vld), 32'd0);
      tick();
    end

    // Clear collides with a nonzero result; clear wins.
    send(v_a);
    repeat (3) tick();
    chk_out("cc.c4", 1'b1, 4'd5, 4'd9);
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    chk("cc.hit", 32'(hit_cnt), 32'd0);

`ifdef TREE_ENCODER_PIPE_THRESH_EN
    pri_thresh = 4'd8;
    send(put(put(fill(4'd0), 4, 4'd7), 9, 4'd8));
    repeat (3) tick();
    chk_out("th.c4", 1'b1, 4'd9, 4'd8);
    tick();
    chk("th.hit", 32'(hit_cnt), 32'd1);
    send(put(put(fill(4'd0), 4, 4'd7), 9, 4'd5));
    repeat (3) tick();
    chk_out("th2.c4", 1'b1, 4'd0, 4'd0);
    tick();
    chk("th2.hit", 32'(hit_cnt), 32'd1);
    pri_thresh = 4'd0;
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
